shift_reg_piso_tx: RTL and testbench
====================================

# shift_reg_piso_tx

Parallel-in serial-out transmitter: the sending end of the serial shift link. It accepts an SHLEN-bit word through a valid/ready handshake and shifts it out one bit per enable tick, MSB-first or LSB-first. It emits a bit strobe that drives the EN input of the serial-in parallel-out receiver register directly. Pacing comes from an external tick, typically the OV output of the time-base counter, or a constant 1 for full rate.

## Interface
Parameters:
- SHLEN, 6, word width in bits (≥2)

Ports:
- CLK  input  1  clock, rising edge active
- RST_N  input  1  reset, synchronous, active-low
- EN  input  1  shift tick; a bit is consumed only on cycles with EN=1 while busy
- LOAD_VALID  input  1  DIN holds a word to send
- LOAD_READY  output  1  block can accept a word this cycle
- DIN  input  SHLEN  parallel word to transmit
- DIR  input  1  bit order, sampled at load: 1 = MSB first (pairs with receiver left shift), 0 = LSB first (pairs with receiver right shift)
- SOUT  output  1  serial data, registered
- BIT_STB  output  1  receiver sample strobe (= EN & BUSY); wire to receiver EN
- BUSY  output  1  frame in progress
- DONE  output  1  one-cycle pulse after the last bit is strobed

## Operation
- Two states:
  - IDLE: LOAD_READY=1, BUSY=0, SOUT=0.
  - SHIFT: LOAD_READY=0, BUSY=1.
- IDLE → SHIFT on a rising edge with LOAD_VALID & LOAD_READY:
  - capture DIN into the shift register and DIR into a direction flag;
  - clear the bit counter (width clog2(SHLEN+1)).
- In SHIFT:
  - SOUT is the head bit: shreg[SHLEN-1] if the direction flag is 1, shreg[0] if 0.
  - On each edge with EN=1, shift the register one place toward the head (fill 0) and increment the counter.
  - EN=0 holds the register, counter and SOUT.
- SHIFT → IDLE on the edge where EN=1 and counter = SHLEN-1, i.e. after the SHLEN-th strobe. DONE is registered high for the following cycle only.
- LOAD_VALID while in SHIFT is ignored; no word is captured and the source must hold it.
- EN while in IDLE has no effect; BIT_STB stays 0.
- DIR and DIN changes during SHIFT have no effect. Both are latched only at load.
- A load in the DONE cycle is legal, because the state is already IDLE. This gives back-to-back frames with one idle cycle between the last strobe and the next first bit.
- RST_N=0 at any edge, including mid-frame, forces IDLE and aborts the frame with no DONE:
  - shift register = 0
  - counter = 0
  - direction flag = 1
  - DONE = 0
- Reset values of outputs: LOAD_READY=1, SOUT=0, BIT_STB=0, BUSY=0, DONE=0.

## Timing
- Load accepted at edge k. From cycle k+1: BUSY=1, LOAD_READY=0, SOUT = first bit.
- BIT_STB is combinational from EN and is valid in the same cycle as EN. The receiver samples SOUT at the edge that ends a BIT_STB=1 cycle, and the transmitter advances at that same edge. SOUT is stable for the full strobe cycle.
- Full rate (EN=1 constantly): bits appear in cycles k+1..k+SHLEN, DONE in cycle k+SHLEN+1, earliest next load at edge k+SHLEN+1.
- General case: with the last strobe at edge m, cycle m+1 has DONE=1, BUSY=0, LOAD_READY=1 and SOUT=0.
- Frame length is exactly SHLEN strobes, independent of the spacing between EN ticks.

## Test plan
- SHLEN=6, DIN=6'b101100, DIR=1, EN=1 constantly:
  - SOUT must be 1,0,1,1,0,0 in cycles k+1..k+6.
  - DONE must be high in cycle k+7 only.
  - Looped into the receiver (DIR=1, EN=BIT_STB), the receiver must read 6'b101100.
- Same word with DIR=0: SOUT must be 0,0,1,1,0,1, and the receiver in right-shift mode must read 6'b101100.
- EN pulsed every 4th cycle, DIN=6'b110001, DIR=1:
  - SOUT must be 1,1,0,0,0,1, each bit held for 4 cycles.
  - BIT_STB must equal EN while BUSY.
  - DONE must follow the 6th strobe by one cycle.
- Word A loaded; LOAD_VALID held with word B during the frame:
  - B must not be captured until the DONE cycle.
  - Frame B must start in the cycle after the DONE cycle.
  - The strobe count for each frame must be exactly 6.
- RST_N low for one edge after the 3rd strobe:
  - Next cycle must show BUSY=0, LOAD_READY=1, SOUT=0, and no DONE pulse.
  - A fresh load afterwards must transmit a full 6 bits correctly.
- EN=1 in IDLE with no load: BIT_STB, SOUT and BUSY must stay 0, and a DIR toggle while BUSY must not alter the bit order of the frame in flight.

Source files
------------

// File: rtl/shift_reg_piso_tx.sv
// Parallel-in serial-out transmitter: takes an SHLEN-bit word via valid/ready and
// shifts it out one bit per EN tick, MSB- or LSB-first, with a receiver strobe.
module shift_reg_piso_tx #(
    parameter int SHLEN = 6
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [SHLEN-1:0] DIN,
    input  logic             DIR,
    output logic             SOUT,
    output logic             BIT_STB,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(SHLEN + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [SHLEN-1:0] shreg;
    logic [SHLEN-1:0] shreg_shifted;
    logic [CW-1:0]    bit_cnt;
    logic             dir_q;
    logic             last_bit;

    // The head always sits at the end selected by dir_q, so shifting moves the next bit into it.
    always_comb begin
        shreg_shifted = dir_q ? {shreg[SHLEN-2:0], 1'b0} : {1'b0, shreg[SHLEN-1:1]};
    end

    assign last_bit   = (bit_cnt == CW'(SHLEN - 1));
    assign LOAD_READY = (state == ST_IDLE);
    assign BUSY       = (state == ST_SHIFT);
    assign BIT_STB    = EN & BUSY;

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            dir_q   <= 1'b1;
            SOUT    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (LOAD_VALID) begin
                        state   <= ST_SHIFT;
                        shreg   <= DIN;
                        dir_q   <= DIR;
                        bit_cnt <= '0;
                        SOUT    <= DIR ? DIN[SHLEN-1] : DIN[0];
                    end
                end
                ST_SHIFT: begin
                    if (EN) begin
                        if (last_bit) begin
                            state   <= ST_IDLE;
                            shreg   <= '0;
                            bit_cnt <= '0;
                            SOUT    <= 1'b0;
                            DONE    <= 1'b1;
                        end else begin
                            shreg   <= shreg_shifted;
                            bit_cnt <= bit_cnt + CW'(1);
                            SOUT    <= dir_q ? shreg_shifted[SHLEN-1] : shreg_shifted[0];
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
// Self-checking bench for shift_reg_piso_tx: table vectors, directed corner cases,
// and random traffic against a queue-based frame model plus a receiver model.
module tb_shift_reg_piso_tx;

    localparam int SHLEN = 6;

    logic             CLK = 1'b0;
    logic             RST_N, EN, LOAD_VALID, LOAD_READY, DIR;
    logic             SOUT, BIT_STB, BUSY, DONE;
    logic [SHLEN-1:0] DIN;

    int n_checks = 0;
    int n_fail   = 0;

    shift_reg_piso_tx #(.SHLEN(SHLEN)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .DIN        (DIN),
        .DIR        (DIR),
        .SOUT       (SOUT),
        .BIT_STB    (BIT_STB),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic             en;
        logic             lv;
        logic [SHLEN-1:0] din;
        logic             dir;
        logic             e_sout;
        logic             e_stb;
        logic             e_busy;
        logic             e_ready;
        logic             e_done;
    } vec_t;

    vec_t vecs[18];

    // Frame model: bits still to send, in wire order; empty means idle.
    bit m_q[$];
    bit m_done = 1'b0;

    logic s_sout, s_stb, s_busy, s_ready, s_done;

    // Receiver model: shifts in SOUT on each strobe, reports a word on DONE.
    bit               rx_dir = 1'b1;
    logic [SHLEN-1:0] rx_word = '0;
    int               rx_cnt = 0;
    logic [SHLEN-1:0] rx_words[$];
    int               rx_counts[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic en, input logic lv, input logic [SHLEN-1:0] din,
                       input logic dir, input logic rst_n);
        bit e_busy;
        bit e_sout;
        EN = en; LOAD_VALID = lv; DIN = din; DIR = dir; RST_N = rst_n;
        @(negedge CLK);
        e_busy = (m_q.size() != 0);
        e_sout = e_busy ? m_q[0] : 1'b0;
        s_sout = SOUT; s_stb = BIT_STB; s_busy = BUSY; s_ready = LOAD_READY; s_done = DONE;
        check("busy",       32'(BUSY),       32'(e_busy));
        check("load_ready", 32'(LOAD_READY), 32'(!e_busy));
        check("sout",       32'(SOUT),       32'(e_sout));
        check("bit_stb",    32'(BIT_STB),    32'(en & e_busy));
        check("done",       32'(DONE),       32'(m_done));
        if (BIT_STB === 1'b1) begin
            rx_cnt++;
            rx_word = rx_dir ? {rx_word[SHLEN-2:0], SOUT} : {SOUT, rx_word[SHLEN-1:1]};
        end
        if (DONE === 1'b1) begin
            rx_words.push_back(rx_word);
            rx_counts.push_back(rx_cnt);
            rx_word = '0;
            rx_cnt  = 0;
        end
        @(posedge CLK);
        if (!rst_n) begin
            m_q.delete();
            m_done  = 1'b0;
            rx_word = '0;
            rx_cnt  = 0;
        end else begin
            m_done = e_busy && en && (m_q.size() == 1);
            if (e_busy && en) begin
                void'(m_q.pop_front());
            end else if (!e_busy && lv) begin
                for (int i = 0; i < SHLEN; i++)
                    m_q.push_back(dir ? din[SHLEN-1-i] : din[i]);
            end
        end
        #1;
    endtask

    task automatic clear_rx();
        rx_words.delete();
        rx_counts.delete();
        rx_word = '0;
        rx_cnt  = 0;
    endtask

    task automatic expect_frames(input string name, input logic [SHLEN-1:0] w0,
                                 input logic [SHLEN-1:0] w1, input int n);
        check({name, "_frames"}, 32'(rx_words.size()), 32'(n));
        if (rx_words.size() >= 1) begin
            check({name, "_word0"},  32'(rx_words[0]), 32'(w0));
            check({name, "_count0"}, 32'(rx_counts[0]), 32'(SHLEN));
        end
        if (n == 2 && rx_words.size() >= 2) begin
            check({name, "_word1"},  32'(rx_words[1]), 32'(w1));
            check({name, "_count1"}, 32'(rx_counts[1]), 32'(SHLEN));
        end
    endtask

    initial begin
        logic [SHLEN-1:0] seqs[2];
        logic [SHLEN-1:0] w;
        bit d;

        // Expected SOUT sequences for 6'b101100, listed first-bit-leftmost.
        seqs[0] = 6'b101100;
        seqs[1] = 6'b001101;
        for (int f = 0; f < 2; f++) begin
            d = (f == 0);
            w = 6'b101100;
            vecs[f*9] = '{1'b1, 1'b1, w, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            for (int b = 1; b <= SHLEN; b++)
                vecs[f*9+b] = '{1'b1, 1'b0, w, d, seqs[f][SHLEN-b], 1'b1, 1'b1, 1'b0, 1'b0};
            vecs[f*9+7] = '{1'b1, 1'b0, w, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            vecs[f*9+8] = '{1'b0, 1'b0, w, d, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        end

        RST_N = 1'b0; EN = 1'b0; LOAD_VALID = 1'b0; DIN = '0; DIR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rst_busy",       32'(BUSY),       32'd0);
        check("rst_load_ready", 32'(LOAD_READY), 32'd1);
        check("rst_sout",       32'(SOUT),       32'd0);
        check("rst_bit_stb",    32'(BIT_STB),    32'd0);
        check("rst_done",       32'(DONE),       32'd0);
        @(posedge CLK);
        #1;

        // Table: full-rate frames of 6'b101100, MSB first then LSB first.
        clear_rx();
        for (int i = 0; i < 18; i++) begin
            rx_dir = vecs[i].dir;
            cyc(vecs[i].en, vecs[i].lv, vecs[i].din, vecs[i].dir, 1'b1);
            check($sformatf("tbl%0d_sout", i),  32'(s_sout),  32'(vecs[i].e_sout));
            check($sformatf("tbl%0d_stb", i),   32'(s_stb),   32'(vecs[i].e_stb));
            check($sformatf("tbl%0d_busy", i),  32'(s_busy),  32'(vecs[i].e_busy));
            check($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(vecs[i].e_ready));
            check($sformatf("tbl%0d_done", i),  32'(s_done),  32'(vecs[i].e_done));
        end
        expect_frames("tbl_rx", 6'b101100, 6'b101100, 2);

        // EN every 4th cycle.
        clear_rx();
        rx_dir = 1'b1;
        for (int i = 0; i < 30; i++)
            cyc(logic'(i % 4 == 3), logic'(i == 0), 6'b110001, 1'b1, 1'b1);
        expect_frames("slow_en", 6'b110001, '0, 1);

        // Word B offered throughout frame A; it may only be taken in the DONE cycle.
        clear_rx();
        cyc(1'b1, 1'b1, 6'b011010, 1'b1, 1'b1);
        for (int i = 1; i <= 7; i++)
            cyc(1'b1, 1'b1, 6'b100111, 1'b1, 1'b1);
        check("b_accept_in_done_cycle", 32'(s_done & s_ready), 32'd1);
        cyc(1'b1, 1'b0, 6'b100111, 1'b1, 1'b1);
        check("b_starts_after_done", 32'(s_busy), 32'd1);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'b0, 6'b000000, 1'b1, 1'b1);
        expect_frames("back2back", 6'b011010, 6'b100111, 2);

        // Reset mid-frame after the third strobe, then a clean frame.
        clear_rx();
        cyc(1'b0, 1'b1, 6'b111011, 1'b1, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 6'b111011, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 6'b111011, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 6'b111011, 1'b1, 1'b1);
        check("abort_busy",  32'(s_busy),  32'd0);
        check("abort_ready", 32'(s_ready), 32'd1);
        check("abort_sout",  32'(s_sout),  32'd0);
        check("abort_done",  32'(s_done),  32'd0);
        repeat (3) cyc(1'b1, 1'b0, 6'b000000, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 6'b010110, 1'b0, 1'b1);
        rx_dir = 1'b0;
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 1'b0, 6'b000000, 1'b1, 1'b1);
        expect_frames("after_abort", 6'b010110, '0, 1);

        // EN in idle does nothing; DIR toggling mid-frame does not change bit order.
        clear_rx();
        rx_dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 6'b111111, logic'(i % 2), 1'b1);
            check("idle_en_stb",  32'(s_stb),  32'd0);
            check("idle_en_sout", 32'(s_sout), 32'd0);
        end
        cyc(1'b0, 1'b1, 6'b100101, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++)
            cyc(1'b1, 1'b0, 6'b011010, logic'(i % 2), 1'b1);
        expect_frames("dir_toggle", 6'b100101, '0, 1);

        // Random traffic against the frame model.
        for (int i = 0; i < 600; i++)
            cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0),
                SHLEN'($urandom), logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 60) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
